mfp_ahb_ram_wait: RTL and testbench
===================================

MFP_AHB_RAM_WAIT -- requirements
Module: mfp_ahb_ram_wait

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, number of word-address bits (RAM depth 2**ADDR_WIDTH x 32).
REQ-002 SHALL have parameter RD_WAIT, default 1, read wait states (legal 1..15).
REQ-003 SHALL have parameter WR_WAIT, default 0, write wait states (legal 0..15).
REQ-004 SHALL have port HCLK, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port HRESET, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have ports HADDR in 32, HBURST in 3 (ignored), HMASTLOCK in 1 (ignored), HPROT in 4 (ignored), HSEL in 1, HSIZE in 3, HTRANS in 2, HWDATA in 32, HWRITE in 1, HREADY in 1, all AHB-Lite standard meaning.
REQ-007 SHALL have outputs HRDATA 32 (read data), HREADYOUT 1 (data phase complete), HRESP 1 (0 OKAY, 1 ERROR).

Function
REQ-008 SHALL accept an address phase when HSEL & HREADY & HTRANS[1] (NONSEQ/SEQ) and HREADYOUT=1, latching HADDR, HSIZE, HWRITE.
REQ-009 SHALL treat IDLE/BUSY or unselected cycles as no-op: HREADYOUT=1, HRESP=0, no RAM access.
REQ-010 SHALL implement states S_IDLE, S_DATA, S_ERR1, S_ERR2; S_IDLE->S_DATA on legal accept, ->S_ERR1 on illegal accept (REQ-017).
REQ-011 SHALL load 4-bit wait counter with RD_WAIT or WR_WAIT on accept, decrement each S_DATA cycle while nonzero.
REQ-012 SHALL drive HREADYOUT = (S_IDLE) or (S_DATA and counter==0); read data phase lasts RD_WAIT+1 cycles, write WR_WAIT+1.
REQ-013 SHALL accept a new transfer in the final S_DATA cycle (pipelined back-to-back, reload counter, stay S_DATA); otherwise return to S_IDLE.
REQ-014 SHALL commit writes to RAM at the clock edge ending the final write data-phase cycle using HWDATA sampled there.
REQ-015 SHALL issue reads from latched address in first data-phase cycle; HRDATA valid in final read data-phase cycle, held until next read completes.
REQ-016 SHALL generate byte enables little-endian: HSIZE=0 lane HADDR[1:0]; HSIZE=1 lanes HADDR[1]*2+{0,1}; HSIZE=2 all four lanes; unselected lanes unchanged.
REQ-017 SHALL classify as illegal (only with MFP_AHB_RAM_ERR_EN): HADDR[31:ADDR_WIDTH+2]!=0, HSIZE>2, halfword with HADDR[0]=1, word with HADDR[1:0]!=0.
REQ-018 SHALL produce two-cycle ERROR: S_ERR1 HRESP=1 HREADYOUT=0; S_ERR2 HRESP=1 HREADYOUT=1; no RAM write; S_ERR2->S_IDLE (new transfer may be accepted in S_ERR2).
REQ-019 SHALL give read-after-write to same address the newly written data with no extra wait.

Reset
REQ-020 SHALL on HRESET=1, immediately and regardless of state, force S_IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-021 SHALL discard any in-flight write when reset asserts mid data phase; RAM contents are not cleared.

Configuration
REQ-022 SHALL with MFP_AHB_RAM_ERR_EN defined perform REQ-017/REQ-018 checks.
REQ-023 SHALL without MFP_AHB_RAM_ERR_EN never assert HRESP; upper address bits ignored (aliasing), HSIZE>2 treated as word, misaligned low bits ignored per HSIZE lane rules.

Verification
REQ-024 SHALL cover: word write 0xDEADBEEF @0x10 then read @0x10, RD_WAIT=2 -> HREADYOUT low 2 cycles, HRDATA=0xDEADBEEF.
REQ-025 SHALL cover: word 0x11223344 @0x20, byte write 0xAA @0x22, read -> 0x11AA3344.
REQ-026 SHALL cover: back-to-back NONSEQ writes @0x0,0x4 then reads, WR_WAIT=0 -> no wait states on writes, correct data each read.
REQ-027 SHALL cover: with ERR_EN, halfword read @0x3 -> HRESP=1 two cycles, HREADYOUT 0 then 1; without ERR_EN -> HRESP stays 0.
REQ-028 SHALL cover: HRESET pulse during write wait cycle -> HREADYOUT=1 same cycle, target word keeps old value.

Source files
------------

// File: rtl/mfp_ahb_ram_wait.sv
// -----------------------------------------------------------------------------
// mfp_ahb_ram_wait
//
// AHB-Lite slave in front of an inferred 2**ADDR_WIDTH x 32 synchronous RAM,
// with a programmable number of wait states for reads (RD_WAIT, 1..15) and
// writes (WR_WAIT, 0..15). Supports byte/halfword/word transfers with
// little-endian byte lanes and pipelined back-to-back transfers.
//
// Optional feature (compile-time macro):
//   MFP_AHB_RAM_ERR_EN  - when defined, out-of-range addresses, HSIZE>2 and
//                         misaligned halfword/word accesses get a two-cycle
//                         ERROR response with no RAM access. When undefined,
//                         HRESP is always OKAY, upper address bits alias and
//                         misaligned low bits simply pick lanes by HSIZE.
//
// Ports:
//   HCLK       in   1  clock, rising edge
//   HRESET     in   1  asynchronous active-high reset
//   HADDR      in  32  byte address (address phase)
//   HBURST     in   3  ignored
//   HMASTLOCK  in   1  ignored
//   HPROT      in   4  ignored
//   HSEL       in   1  slave select
//   HSIZE      in   3  transfer size (0 byte, 1 halfword, 2 word)
//   HTRANS     in   2  transfer type (bit 1 set = NONSEQ/SEQ)
//   HWDATA     in  32  write data (data phase)
//   HWRITE     in   1  1 = write
//   HREADY     in   1  bus ready (previous data phase done)
//   HRDATA     out 32  read data
//   HREADYOUT  out  1  this slave's data phase complete
//   HRESP      out  1  0 OKAY, 1 ERROR
// -----------------------------------------------------------------------------
module mfp_ahb_ram_wait #(
   parameter int ADDR_WIDTH = 8,
   parameter int RD_WAIT    = 1,
   parameter int WR_WAIT    = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HADDR,
   input  logic [2:0]  HBURST,
   input  logic        HMASTLOCK,
   input  logic [3:0]  HPROT,
   input  logic        HSEL,
   input  logic [2:0]  HSIZE,
   input  logic [1:0]  HTRANS,
   input  logic [31:0] HWDATA,
   input  logic        HWRITE,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam int         DEPTH  = 1 << ADDR_WIDTH;
   localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
   localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            be_q, be_d;
   logic                  write_q, write_d;
   logic [31:0]           hrdata_q, hrdata_d;

   logic        hreadyout;
   logic        hresp;
   logic        accept;
   logic        illegal;
   logic [3:0]  be_in;
   logic        rd_en;
   logic        rd_final;
   logic        wr_commit;
   logic [31:0] ram_rd;

   // Bus attributes with no function here are folded into a dummy net.
   logic unused_inputs;
   assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT, HADDR};

   // ---------------- output decode (per state) ----------------
   always_comb begin
      hreadyout = 1'b1;
      hresp     = 1'b0;
      case (state_q)
         S_IDLE: hreadyout = 1'b1;
         S_DATA: hreadyout = (cnt_q == 4'd0);
         S_ERR1: begin
            hreadyout = 1'b0;
            hresp     = 1'b1;
         end
         S_ERR2: begin
            hreadyout = 1'b1;
            hresp     = 1'b1;
         end
         default: hreadyout = 1'b1;
      endcase
   end

   assign HREADYOUT = hreadyout;
   assign HRESP     = hresp;

   assign accept = HSEL & HREADY & HTRANS[1] & hreadyout;

   // Little-endian lane selection; HSIZE>2 falls through to a full word.
   always_comb begin
      case (HSIZE)
         3'd0:    be_in = 4'b0001 << HADDR[1:0];
         3'd1:    be_in = HADDR[1] ? 4'b1100 : 4'b0011;
         default: be_in = 4'b1111;
      endcase
   end

`ifdef MFP_AHB_RAM_ERR_EN
   always_comb begin
      illegal = (HADDR[31:ADDR_WIDTH+2] != '0)
              | (HSIZE > 3'd2)
              | ((HSIZE == 3'd1) & HADDR[0])
              | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
   end
`else
   assign illegal = 1'b0;
`endif

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      be_d    = be_q;
      write_d = write_q;

      if (state_q == S_DATA && cnt_q != 4'd0)
         cnt_d = cnt_q - 4'd1;

      // Whenever the current data phase is completing (or we are idle) a new
      // address phase may be taken; otherwise fall back to idle.
      if (hreadyout) begin
         if (accept) begin
            addr_d  = HADDR[ADDR_WIDTH+1:2];
            be_d    = be_in;
            write_d = HWRITE;
            if (illegal) begin
               state_d = S_ERR1;
               cnt_d   = 4'd0;
            end else begin
               state_d = S_DATA;
               cnt_d   = HWRITE ? WR_CNT : RD_CNT;
            end
         end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      end else if (state_q == S_ERR1) begin
         state_d = S_ERR2;
      end
   end

   // ---------------- state registers ----------------
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         be_q     <= 4'd0;
         write_q  <= 1'b0;
         hrdata_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         write_q  <= write_d;
         hrdata_q <= hrdata_d;
      end
   end

   // ---------------- RAM ----------------
   assign rd_en     = (state_q == S_DATA) & ~write_q;
   assign rd_final  = rd_en & (cnt_q == 4'd0);
   assign wr_commit = (state_q == S_DATA) & write_q & (cnt_q == 4'd0);

   // The RAM output register is refreshed every read data-phase cycle; since
   // RD_WAIT >= 1 it holds the addressed word by the final cycle. Once that
   // read completes the value is copied to a hold register so HRDATA stays
   // put through later transfers until the next read finishes.
   assign hrdata_d = rd_final ? ram_rd : hrdata_q;
   assign HRDATA   = rd_final ? ram_rd : hrdata_q;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_q;

         always_ff @(posedge HCLK) begin
            if (wr_commit && be_q[gi] && !HRESET)
               mem[addr_q] <= HWDATA[gi*8 +: 8];
            if (rd_en)
               rd_q <= mem[addr_q];
         end

         assign ram_rd[gi*8 +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: tb/tb_mfp_ahb_ram_wait.sv
// -----------------------------------------------------------------------------
// Testbench for mfp_ahb_ram_wait.
// Instance A: RD_WAIT=2, WR_WAIT=0. Instance B: RD_WAIT=1, WR_WAIT=2.
// Both share the bus inputs; separate HSEL lines pick the target and the
// observed outputs follow use_b.
// -----------------------------------------------------------------------------
module tb_mfp_ahb_ram_wait;

   logic        HCLK;
   logic        HRESET;
   logic [31:0] HADDR;
   logic [2:0]  HBURST;
   logic        HMASTLOCK;
   logic [3:0]  HPROT;
   logic        hsel_a, hsel_b;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic        HREADY;

   logic [31:0] hrdata_a, hrdata_b;
   logic        hreadyout_a, hreadyout_b;
   logic        hresp_a, hresp_b;

   logic        use_b;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic        hresp;

   assign hrdata    = use_b ? hrdata_b    : hrdata_a;
   assign hreadyout = use_b ? hreadyout_b : hreadyout_a;
   assign hresp     = use_b ? hresp_b     : hresp_a;

   mfp_ahb_ram_wait #(.ADDR_WIDTH(8), .RD_WAIT(2), .WR_WAIT(0)) dut_a (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST),
      .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSEL(hsel_a), .HSIZE(HSIZE),
      .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HREADY(HREADY),
      .HRDATA(hrdata_a), .HREADYOUT(hreadyout_a), .HRESP(hresp_a)
   );

   mfp_ahb_ram_wait #(.ADDR_WIDTH(8), .RD_WAIT(1), .WR_WAIT(2)) dut_b (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST),
      .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSEL(hsel_b), .HSIZE(HSIZE),
      .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HREADY(HREADY),
      .HRDATA(hrdata_b), .HREADYOUT(hreadyout_b), .HRESP(hresp_b)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One non-pipelined transfer: address phase, then data phase until
   // HREADYOUT. Returns with the bench sitting in the final data-phase cycle.
   task automatic do_xfer(input bit b, input bit wr, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int waits,
                          output bit resp);
      @(posedge HCLK); #1;
      use_b  = b;
      hsel_a = ~b;
      hsel_b = b;
      HTRANS = 2'b10;
      HADDR  = addr;
      HWRITE = wr;
      HSIZE  = sz;
      @(posedge HCLK); #1;
      HTRANS = 2'b00;
      hsel_a = 1'b0;
      hsel_b = 1'b0;
      HWDATA = wdata;
      waits  = 0;
      resp   = 1'b0;
      while (!hreadyout && waits < 20) begin
         resp = resp | hresp;
         @(posedge HCLK); #1;
         waits++;
      end
      rdata = hrdata;
      resp  = resp | hresp;
   endtask

   typedef struct {
      bit          inst_b;
      bit          wr;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_waits;
   } vec_t;

   vec_t vecs [16];

   initial begin
      logic [31:0] rdata;
      int          waits;
      bit          resp;

      HRESET = 1'b1; HADDR = '0; HBURST = '0; HMASTLOCK = 1'b0; HPROT = 4'b0011;
      hsel_a = 1'b0; hsel_b = 1'b0; HSIZE = 3'd2; HTRANS = 2'b00;
      HWDATA = '0; HWRITE = 1'b0; HREADY = 1'b1; use_b = 1'b0;

      //           b  wr size  addr        wdata         exp_rdata     waits
      vecs[0]  = '{0, 1, 3'd2, 32'h010, 32'hDEADBEEF, 32'h00000000, 0};
      vecs[1]  = '{0, 0, 3'd2, 32'h010, 32'h00000000, 32'hDEADBEEF, 2};
      vecs[2]  = '{0, 1, 3'd2, 32'h020, 32'h11223344, 32'h00000000, 0};
      vecs[3]  = '{0, 1, 3'd0, 32'h022, 32'hFFAAFFFF, 32'h00000000, 0};
      vecs[4]  = '{0, 0, 3'd2, 32'h020, 32'h00000000, 32'h11AA3344, 2};
      vecs[5]  = '{0, 1, 3'd2, 32'h024, 32'h00000000, 32'h00000000, 0};
      vecs[6]  = '{0, 1, 3'd1, 32'h026, 32'hBEEF5555, 32'h00000000, 0};
      vecs[7]  = '{0, 1, 3'd1, 32'h024, 32'hAAAA1234, 32'h00000000, 0};
      vecs[8]  = '{0, 0, 3'd0, 32'h027, 32'h00000000, 32'hBEEF1234, 2};
      vecs[9]  = '{0, 1, 3'd2, 32'h3FC, 32'hA5A5A5A5, 32'h00000000, 0};
      vecs[10] = '{0, 0, 3'd2, 32'h3FC, 32'h00000000, 32'hA5A5A5A5, 2};
      vecs[11] = '{0, 1, 3'd0, 32'h3FC, 32'h000000C3, 32'h00000000, 0};
      vecs[12] = '{0, 0, 3'd2, 32'h3FC, 32'h00000000, 32'hA5A5A5C3, 2};
      vecs[13] = '{1, 1, 3'd2, 32'h040, 32'h12345678, 32'h00000000, 2};
      vecs[14] = '{1, 0, 3'd2, 32'h040, 32'h00000000, 32'h12345678, 1};
      vecs[15] = '{0, 0, 3'd2, 32'h010, 32'h00000000, 32'hDEADBEEF, 2};

      // ---- reset state ----
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_ready_a", 32'(hreadyout_a), 32'd1);
      check("rst_resp_a",  32'(hresp_a),     32'd0);
      check("rst_rdata_a", hrdata_a,         32'd0);
      check("rst_ready_b", 32'(hreadyout_b), 32'd1);
      check("rst_rdata_b", hrdata_b,         32'd0);
      HRESET = 1'b0;

      // ---- table-driven single transfers ----
      for (int i = 0; i < 16; i++) begin
         do_xfer(vecs[i].inst_b, vecs[i].wr, vecs[i].sz, vecs[i].addr,
                 vecs[i].wdata, rdata, waits, resp);
         $display("vec %0d inst=%0d wr=%0d size=%0d addr=%h wdata=%h rdata=%h waits=%0d",
                  i, vecs[i].inst_b, vecs[i].wr, vecs[i].sz, vecs[i].addr,
                  vecs[i].wdata, rdata, waits);
         check($sformatf("vec%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
         check($sformatf("vec%0d_resp", i), 32'(resp), 32'd0);
         if (!vecs[i].wr)
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      end

      // ---- pipelined writes @0,@4,@8 then read @8 right behind the write ----
      @(posedge HCLK); #1;
      use_b = 1'b0; hsel_a = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h0;
      @(posedge HCLK); #1;
      check("b2b_w0_ready", 32'(hreadyout), 32'd1);
      HWDATA = 32'h0BADF00D; HADDR = 32'h4;
      @(posedge HCLK); #1;
      check("b2b_w4_ready", 32'(hreadyout), 32'd1);
      HWDATA = 32'h600DCAFE; HADDR = 32'h8;
      @(posedge HCLK); #1;
      check("b2b_w8_ready", 32'(hreadyout), 32'd1);
      HWDATA = 32'h13579BDF; HADDR = 32'h8; HWRITE = 1'b0;
      @(posedge HCLK); #1;
      hsel_a = 1'b0; HTRANS = 2'b00;
      check("raw_first_wait", 32'(hreadyout), 32'd0);
      waits = 0;
      while (!hreadyout && waits < 20) begin
         @(posedge HCLK); #1;
         waits++;
      end
      $display("pipelined read @8 rdata=%h waits=%0d", hrdata, waits);
      check("raw_waits", 32'(waits), 32'd2);
      check("raw_rdata", hrdata, 32'h13579BDF);
      do_xfer(0, 0, 3'd2, 32'h0, 32'h0, rdata, waits, resp);
      $display("read @0 rdata=%h", rdata);
      check("b2b_rd0", rdata, 32'h0BADF00D);
      do_xfer(0, 0, 3'd2, 32'h4, 32'h0, rdata, waits, resp);
      $display("read @4 rdata=%h", rdata);
      check("b2b_rd4", rdata, 32'h600DCAFE);

      // ---- no accept when HREADY low or slave unselected ----
      @(posedge HCLK); #1;
      use_b = 1'b0; hsel_a = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h10; HREADY = 1'b0;
      @(posedge HCLK); #1;
      check("hready_low_noaccept", 32'(hreadyout), 32'd1);
      HREADY = 1'b1; hsel_a = 1'b0;
      @(posedge HCLK); #1;
      check("unselected_noaccept", 32'(hreadyout), 32'd1);
      HTRANS = 2'b00;
      $display("idle/unselected cycles done");

      // ---- misaligned halfword read @0x3 ----
      @(posedge HCLK); #1;
      use_b = 1'b0; hsel_a = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd1; HADDR = 32'h3;
      @(posedge HCLK); #1;
      hsel_a = 1'b0; HTRANS = 2'b00;
`ifdef MFP_AHB_RAM_ERR_EN
      check("err_c1_resp",  32'(hresp),     32'd1);
      check("err_c1_ready", 32'(hreadyout), 32'd0);
      @(posedge HCLK); #1;
      check("err_c2_resp",  32'(hresp),     32'd1);
      check("err_c2_ready", 32'(hreadyout), 32'd1);
      @(posedge HCLK); #1;
      check("err_c3_resp",  32'(hresp),     32'd0);
      check("err_c3_ready", 32'(hreadyout), 32'd1);
`else
      check("noerr_c1_resp",  32'(hresp),     32'd0);
      check("noerr_c1_ready", 32'(hreadyout), 32'd0);
      @(posedge HCLK); #1;
      check("noerr_c2_resp",  32'(hresp),     32'd0);
      check("noerr_c2_ready", 32'(hreadyout), 32'd0);
      @(posedge HCLK); #1;
      check("noerr_c3_resp",  32'(hresp),     32'd0);
      check("noerr_c3_ready", 32'(hreadyout), 32'd1);
`endif
      $display("halfword read @3 sequence done");

      // ---- reset pulse in a write wait cycle on instance B ----
      @(posedge HCLK); #1;
      use_b = 1'b1; hsel_b = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h40;
      @(posedge HCLK); #1;
      hsel_b = 1'b0; HTRANS = 2'b00; HWDATA = 32'hCAFEF00D;
      check("rstmid_wait_low", 32'(hreadyout), 32'd0);
      #2;
      HRESET = 1'b1;
      #1;
      check("rstmid_ready", 32'(hreadyout), 32'd1);
      check("rstmid_resp",  32'(hresp),     32'd0);
      check("rstmid_rdata", hrdata,         32'd0);
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      do_xfer(1, 0, 3'd2, 32'h40, 32'h0, rdata, waits, resp);
      $display("read after reset @40 rdata=%h waits=%0d", rdata, waits);
      check("rstmid_oldval", rdata, 32'h12345678);
      check("rstmid_waits",  32'(waits), 32'd1);

      @(posedge HCLK); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
